// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and the round-robin search for rr_arbiter_8
package arb_pkg;

    localparam int NREQ     = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    // First set bit of req searching ptr+1, ptr+2, ... wrapping 7 -> 0; ptr itself is checked last
    function automatic logic [IDX_W-1:0] next_winner(input logic [NREQ-1:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] idx;
        logic             found;
        w     = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// decoder_3to8: enabled 3-to-8 one-hot decoder, A is the MSB of the select
module decoder_3to8 (
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       en,
    output logic [7:0] Y
);

    // One-hot decode of {A,B,C}, all zero when disabled
    always_comb Y = en ? 8'h01 << {A, B, C} : 8'h00;

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter holding each grant until release; optional hold limit via ARB_HOLD_LIMIT_EN
module rr_arbiter_8
    import arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] grant_idx,
    output logic       grant_en,
    output logic [7:0] grant,
    output logic       busy
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  cand;
    logic [IDX_W-1:0] win;
    logic             owner_done;
    logic             preempt;
`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Next grant: the owner is masked out so a handoff never lands back on it
    always_comb begin
        owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_q;
        cand        = (state_q == ARB_GRANT) ? req & ~owner_oh : req;
        win         = next_winner(cand, ptr_q);
        owner_done  = !req[grant_idx_q];
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d  = hold_cnt_q;
        preempt     = hold_cnt_q == HOLD_W'(MAX_HOLD - 1);
`else
        preempt     = 1'b0;
`endif
        if ((state_q == ARB_IDLE && |req) || (state_q == ARB_GRANT && (owner_done || preempt) && |cand)) begin
            state_d     = ARB_GRANT;
            grant_idx_d = win;
            ptr_d       = win;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_d  = '0;
`endif
        end else if (state_q == ARB_GRANT && owner_done) begin
            state_d = ARB_IDLE;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (state_q == ARB_GRANT && !preempt) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
    end

    // State register; pointer resets to 7 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= IDX_W'(NREQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign grant_idx = grant_idx_q;
    assign grant_en  = state_q == ARB_GRANT;
    assign busy      = grant_en | (|req);

    decoder_3to8 u_dec (
        .A  (grant_idx_q[2]),
        .B  (grant_idx_q[1]),
        .C  (grant_idx_q[0]),
        .en (grant_en),
        .Y  (grant)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed scoreboard bench for rr_arbiter_8; hold-limit checks when ARB_HOLD_LIMIT_EN is defined
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic [7:0] grant;
    logic       busy;

    typedef struct {
        string      tag;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       en;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    rr_arbiter_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [2:0] idx, input logic en, input logic [7:0] r);
        exp_t e;
        e.tag   = tag;
        e.idx   = idx;
        e.en    = en;
        e.grant = en ? 8'h01 << idx : 8'h00;
        e.busy  = en | (|r);
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL scoreboard empty observed=0 expected>0");
            return;
        end
        e = sb.pop_front();
        assert (grant === e.grant) else begin
            miscompares++;
            $error("FAIL %s grant observed=%h expected=%h", e.tag, grant, e.grant);
        end
        assert (grant_en === e.en) else begin
            miscompares++;
            $error("FAIL %s grant_en observed=%b expected=%b", e.tag, grant_en, e.en);
        end
        assert (grant_idx === e.idx) else begin
            miscompares++;
            $error("FAIL %s grant_idx observed=%0d expected=%0d", e.tag, grant_idx, e.idx);
        end
        assert (busy === e.busy) else begin
            miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
        end
    endtask

    // Drive req, clock once, compare the registered result just after the edge
    task automatic cycle(input string tag, input logic [7:0] r, input logic [2:0] idx, input logic en);
        req = r;
        push(tag, idx, en, r);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic do_reset(input logic [7:0] r);
        req   = r;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        push("reset", 3'd0, 1'b0, r);
        check();
        rst_n = 1'b1;
    endtask

    initial begin
        req   = 8'h00;
        rst_n = 1'b1;
        #2;
        do_reset(8'hFF);
        cycle("t1_first", 8'hFF, 3'd0, 1'b1);
        cycle("t1_hold",  8'hFF, 3'd0, 1'b1);
        cycle("t2_hold0", 8'h81, 3'd0, 1'b1);
        cycle("t2_to7",   8'h80, 3'd7, 1'b1);
        cycle("t2_wrap0", 8'h01, 3'd0, 1'b1);
        cycle("t2_idle",  8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("t3_grant2", 8'h04, 3'd2, 1'b1);
        cycle("t3_idle",  8'h00, 3'd2, 1'b0);
        cycle("t4_own2",  8'h04, 3'd2, 1'b1);
        cycle("t4_hold2", 8'h16, 3'd2, 1'b1);
        cycle("t4_to4",   8'h12, 3'd4, 1'b1);
        cycle("t4_hold4", 8'h12, 3'd4, 1'b1);
        cycle("t4_to1",   8'h02, 3'd1, 1'b1);
        cycle("t5_to5",   8'h20, 3'd5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        push("t5_async", 3'd0, 1'b0, 8'h20);
        check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("t5_ptr7",  8'h30, 3'd4, 1'b1);
        cycle("rr_to5",   8'h20, 3'd5, 1'b1);
        cycle("rr_hold5", 8'h30, 3'd5, 1'b1);
        cycle("rr_to6",   8'h50, 3'd6, 1'b1);
        cycle("rr_to4",   8'h10, 3'd4, 1'b1);
        cycle("rr_idle",  8'h00, 3'd4, 1'b0);
        do_reset(8'h00);
`ifdef ARB_HOLD_LIMIT_EN
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) cycle("t6_alt", 8'h03, (k == 1) ? 3'd1 : 3'd0, 1'b1);
        cycle("t6_drop", 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 40; i++) cycle("t6_sole", 8'h01, 3'd0, 1'b1);
`else
        for (int i = 0; i < 40; i++) cycle("t6_nolimit", 8'h03, 3'd0, 1'b1);
`endif
        cycle("end_idle", 8'h00, 3'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
